// File: rtl/cipher_msg_feeder_pkg.sv
// rtl/cipher_msg_feeder_pkg.sv - shared FSM encoding, FIFO entry type and WAIT counter width
package cipher_feeder_pkg;

  localparam int WAIT_CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEWMSG = 3'd1,
    S_READY  = 3'd2,
    S_SEND   = 3'd3,
    S_WAIT   = 3'd4
  } feeder_state_e;

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_NEWMSG = S_NEWMSG;
  localparam logic [2:0] ST_READY  = S_READY;
  localparam logic [2:0] ST_SEND   = S_SEND;
  localparam logic [2:0] ST_WAIT   = S_WAIT;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // WAIT counter holds at all-ones instead of wrapping.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cipher_msg_feeder_if.sv
// rtl/cipher_msg_feeder_if.sv - host byte-stream handshake bundle (valid/ready with last marker)
interface cipher_msg_feeder_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/cipher_msg_feeder_sync_fifo.sv
// rtl/cipher_msg_feeder_sync_fifo.sv - synchronous FIFO with registered head and wrap-bit pointers
module sync_fifo
  import cipher_feeder_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fifo_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T             mem_q [DEPTH];
  T             head_q, head_d;
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    // The head slot may be the one being written this cycle.
    if (do_push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/cipher_msg_feeder.sv
// rtl/cipher_msg_feeder.sv - framed byte feeder for the S-box cipher; FEEDER_STATS_EN adds message/byte counters
module cipher_msg_feeder
  import cipher_feeder_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cipher_msg_feeder_if.slave    host,
  input  logic                  key_load_i,
  input  logic [7:0]            key_in_i,
  input  logic                  out_flag_i,
  output logic                  new_msg_o,
  output logic                  in_valid_o,
  output logic [7:0]            in_o,
  output logic [7:0]            key_o,
  output logic                  timeout_err_o
`ifdef FEEDER_STATS_EN
  ,
  output logic [15:0]           msg_count_o,
  output logic [15:0]           byte_count_o
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TO_LIM = WAIT_CNT_W'(TIMEOUT);

  logic [2:0]            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]            key_q, key_d;
  logic [7:0]            shadow_q, shadow_d;
  logic [7:0]            in_q, in_d;
  logic                  last_q, last_d;
  logic                  timeout_err_q, timeout_err_d;

  fifo_entry_t wr_entry;
  fifo_entry_t head;
  logic        fifo_full, fifo_empty;
  logic        push, pop;

  assign host.s_ready = rst_n && !fifo_full;
  assign push         = host.s_valid && host.s_ready;
  assign wr_entry     = '{last: host.s_last, data: host.s_data};

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fifo_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    key_d         = key_q;
    shadow_d      = key_load_i ? key_in_i : shadow_q;
    in_d          = in_q;
    last_d        = last_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_NEWMSG;
          key_d   = shadow_q;
        end
      end
      ST_NEWMSG: state_d = ST_READY;
      ST_READY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          in_d    = head.data;
          last_d  = head.last;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        // A result arriving on the final allowed cycle still counts as success.
        if (out_flag_i) begin
          state_d = last_q ? ST_IDLE : ST_READY;
        end else if (cnt_d >= TO_LIM) begin
          timeout_err_d = 1'b1;
          state_d       = last_q ? ST_IDLE : ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      key_q         <= 8'h00;
      shadow_q      <= 8'h00;
      in_q          <= 8'h00;
      last_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_q         <= key_d;
      shadow_q      <= shadow_d;
      in_q          <= in_d;
      last_q        <= last_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign new_msg_o     = (state_q == ST_NEWMSG);
  assign in_valid_o    = (state_q == ST_SEND);
  assign in_o          = in_q;
  assign key_o         = key_q;
  assign timeout_err_o = timeout_err_q;

`ifdef FEEDER_STATS_EN
  logic [15:0] msg_count_q, byte_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_count_q  <= 16'h0000;
      byte_count_q <= 16'h0000;
    end else begin
      if (state_q == ST_NEWMSG) msg_count_q <= msg_count_q + 16'd1;
      if (state_q == ST_SEND) byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign msg_count_o  = msg_count_q;
  assign byte_count_o = byte_count_q;
`endif

endmodule

// File: tb/tb_cipher_msg_feeder.sv
// tb/tb_cipher_msg_feeder.sv - randomized self-checking bench for cipher_msg_feeder
module tb_cipher_msg_feeder;
  import cipher_feeder_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 15;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       key_load = 1'b0;
  logic [7:0] key_in   = 8'h00;
  logic       out_flag = 1'b0;
  logic       new_msg, in_valid, timeout_err;
  logic [7:0] in_byte, key;
`ifdef FEEDER_STATS_EN
  logic [15:0] msg_count, byte_count;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int         nm_cyc[$];
  logic [7:0] nm_key[$];
  int         iv_cyc[$];
  logic [7:0] iv_data[$];
  int         dly_q[$];
  int         resp_mode  = 0;
  int         resp_fixed = 1;
  int         flag_cnt   = 0;

  cipher_msg_feeder_if bus();

  cipher_msg_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (bus),
    .key_load_i    (key_load),
    .key_in_i      (key_in),
    .out_flag_i    (out_flag),
    .new_msg_o     (new_msg),
    .in_valid_o    (in_valid),
    .in_o          (in_byte),
    .key_o         (key),
    .timeout_err_o (timeout_err)
`ifdef FEEDER_STATS_EN
    ,
    .msg_count_o   (msg_count),
    .byte_count_o  (byte_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cipher stand-in: logs pulses and raises out_flag d cycles after each strobe (d=0: never).
  always @(posedge clk) begin : cipher_model
    int d;
    #1;
    out_flag = 1'b0;
    if (flag_cnt > 0) begin
      flag_cnt = flag_cnt - 1;
      if (flag_cnt == 0) out_flag = 1'b1;
    end
    if (rst_n) begin
      if (new_msg) begin
        nm_cyc.push_back(cyc);
        nm_key.push_back(key);
      end
      if (in_valid) begin
        d = (resp_mode == 0) ? 0 : (resp_mode == 1) ? resp_fixed : int'($urandom_range(TIMEOUT, 1));
        iv_cyc.push_back(cyc);
        iv_data.push_back(in_byte);
        dly_q.push_back(d);
        flag_cnt = d;
      end
    end else begin
      flag_cnt = 0;
    end
  end

  function automatic int wait_len(input int d);
    return (d == 0) ? TIMEOUT : d;
  endfunction

  task automatic clear_log();
    nm_cyc.delete(); nm_key.delete(); iv_cyc.delete(); iv_data.delete(); dly_q.delete();
  endtask

  task automatic load_key(input logic [7:0] k);
    @(negedge clk); key_load = 1'b1; key_in = k;
    @(negedge clk); key_load = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, output int acc);
    int t = 0;
    @(negedge clk);
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (!bus.s_ready && t < 300) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    acc = (t < 300) ? cyc : -1;
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    int t = 0;
    while (iv_cyc.size() < n && t < budget) begin @(posedge clk); t++; end
    ok = (iv_cyc.size() >= n);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
    checks++; if ({new_msg, in_valid, timeout_err} !== 3'b000) begin fails++; $display("FAIL reset_pulses: got %b want 000", {new_msg, in_valid, timeout_err}); end
    checks++; if ({in_byte, key} !== 16'h0000) begin fails++; $display("FAIL reset_in_key: got %h want 0000", {in_byte, key}); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL release_s_ready: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_single_message();
    int acc[5]; bit ok;
    clear_log(); resp_mode = 1; resp_fixed = 1;
    load_key(8'hAA);
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1), (i == 4), acc[i]);
    wait_strobes(5, 100, ok);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL single_strobes: got %0d want 5", iv_cyc.size()); end
    checks++; if (nm_cyc.size() !== 1) begin fails++; $display("FAIL single_newmsg_count: got %0d want 1", nm_cyc.size()); end
    checks++; if (nm_cyc[0] !== acc[0] + 1) begin fails++; $display("FAIL single_newmsg_cycle: got %0d want %0d", nm_cyc[0], acc[0] + 1); end
    checks++; if (nm_key[0] !== 8'hAA) begin fails++; $display("FAIL single_key: got %h want aa", nm_key[0]); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (iv_data[i] !== 8'(i + 1)) begin fails++; $display("FAIL single_data[%0d]: got %h want %h", i, iv_data[i], 8'(i + 1)); end
      checks++; if (iv_cyc[i] !== acc[0] + 3 + 3 * i) begin fails++; $display("FAIL single_cycle[%0d]: got %0d want %0d", i, iv_cyc[i], acc[0] + 3 + 3 * i); end
    end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL single_timeout_err: got %b want 0", timeout_err); end
    checks++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL single_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_timeout();
    int acc[5]; bit ok;
    clear_log(); resp_mode = 0;
    for (int i = 0; i < 5; i++) push_byte(8'(i + 1), (i == 4), acc[i]);
    wait_strobes(5, 200, ok);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL timeout_strobes: got %0d want 5", iv_cyc.size()); end
    checks++; if (iv_cyc[0] !== acc[0] + 3) begin fails++; $display("FAIL timeout_first: got %0d want %0d", iv_cyc[0], acc[0] + 3); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (iv_cyc[i] - iv_cyc[i-1] !== TIMEOUT + 2) begin fails++; $display("FAIL timeout_period[%0d]: got %0d want %0d", i, iv_cyc[i] - iv_cyc[i-1], TIMEOUT + 2); end
      checks++; if (iv_data[i] !== 8'(i + 1)) begin fails++; $display("FAIL timeout_data[%0d]: got %h want %h", i, iv_data[i], 8'(i + 1)); end
    end
    checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    checks++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL timeout_idle: got %0d want %0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_stats();
`ifdef FEEDER_STATS_EN
    checks++; if (msg_count !== 16'd2) begin fails++; $display("FAIL stats_msg: got %0d want 2", msg_count); end
    checks++; if (byte_count !== 16'd10) begin fails++; $display("FAIL stats_byte: got %0d want 10", byte_count); end
`endif
  endtask

  task automatic test_full_fifo();
    logic [7:0] d[10]; int acc[10]; bit ok;
    clear_log(); resp_mode = 0;
    foreach (d[i]) d[i] = 8'($urandom);
    push_byte(d[0], 1'b1, acc[0]);
    for (int i = 1; i <= 8; i++) push_byte(d[i], 1'b0, acc[i]);
    @(negedge clk);
    checks++; if (acc[8] !== acc[0] + 8) begin fails++; $display("FAIL full_accept8: got %0d want %0d", acc[8], acc[0] + 8); end
    checks++; if (bus.s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready: got %b want 0", bus.s_ready); end
    push_byte(d[9], 1'b1, acc[9]);
    resp_mode = 1; resp_fixed = 1;
    wait_strobes(10, 400, ok);
    repeat (6) @(posedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL full_strobes: got %0d want 10", iv_cyc.size()); end
    checks++; if (iv_cyc[1] !== acc[0] + 22) begin fails++; $display("FAIL full_first_pop: got %0d want %0d", iv_cyc[1], acc[0] + 22); end
    checks++; if (acc[9] !== acc[0] + 23) begin fails++; $display("FAIL full_ninth_accept: got %0d want %0d", acc[9], acc[0] + 23); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (iv_data[i] !== d[i]) begin fails++; $display("FAIL full_data[%0d]: got %h want %h", i, iv_data[i], d[i]); end
    end
    checks++; if (nm_cyc.size() !== 2) begin fails++; $display("FAIL full_newmsg_count: got %0d want 2", nm_cyc.size()); end
  endtask

  task automatic test_key_change();
    logic [7:0] b[7]; int acc[7]; int exp_c; int exp_nm; bit ok;
    clear_log(); resp_mode = 2;
    load_key(8'hAA);
    foreach (b[i]) b[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) push_byte(b[i], (i == 3) || (i == 6), acc[i]);
    load_key(8'h55);
    wait_strobes(7, 300, ok);
    repeat (20) @(posedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL key_strobes: got %0d want 7", iv_cyc.size()); end
    exp_c = acc[0] + 3; exp_nm = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) exp_c = exp_c + wait_len(dly_q[i-1]) + 2 + ((i == 4) ? 2 : 0);
      if (i == 4) exp_nm = exp_c - 2;
      checks++; if (iv_cyc[i] !== exp_c) begin fails++; $display("FAIL key_cycle[%0d]: got %0d want %0d", i, iv_cyc[i], exp_c); end
      checks++; if (iv_data[i] !== b[i]) begin fails++; $display("FAIL key_data[%0d]: got %h want %h", i, iv_data[i], b[i]); end
    end
    checks++; if (nm_cyc.size() !== 2) begin fails++; $display("FAIL key_newmsg_count: got %0d want 2", nm_cyc.size()); end
    checks++; if (nm_cyc[1] !== exp_nm) begin fails++; $display("FAIL key_newmsg2_cycle: got %0d want %0d", nm_cyc[1], exp_nm); end
    checks++; if (nm_key[0] !== 8'hAA) begin fails++; $display("FAIL key_msg1: got %h want aa", nm_key[0]); end
    checks++; if (nm_key[1] !== 8'h55) begin fails++; $display("FAIL key_msg2: got %h want 55", nm_key[1]); end
  endtask

  task automatic test_reset_mid();
    int acc[5]; bit ok;
    clear_log(); resp_mode = 0;
    for (int i = 0; i < 5; i++) push_byte(8'hC1 + 8'(i), (i == 4), acc[i]);
    wait_strobes(3, 200, ok);
    repeat (4) @(posedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL mid_strobes: got %0d want 3", iv_cyc.size()); end
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({in_byte, key} !== 16'h0000) begin fails++; $display("FAIL mid_in_key: got %h want 0000", {in_byte, key}); end
    checks++; if ({bus.s_ready, new_msg, in_valid, timeout_err} !== 4'b0000) begin fails++; $display("FAIL mid_flags: got %b want 0000", {bus.s_ready, new_msg, in_valid, timeout_err}); end
    checks++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL mid_state: got %0d want %0d", dut.state_q, ST_IDLE); end
`ifdef FEEDER_STATS_EN
    checks++; if ({msg_count, byte_count} !== 32'd0) begin fails++; $display("FAIL mid_stats: got %h want 0", {msg_count, byte_count}); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (30) @(posedge clk);
    @(negedge clk);
    checks++; if (iv_cyc.size() + nm_cyc.size() !== 0) begin fails++; $display("FAIL mid_no_output: got %0d pulses want 0", iv_cyc.size() + nm_cyc.size()); end
    checks++; if (bus.s_ready !== 1'b1) begin fails++; $display("FAIL mid_s_ready: got %b want 1", bus.s_ready); end
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    test_reset();
    test_single_message();
    test_timeout();
    test_stats();
    test_full_fifo();
    test_key_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cipher_msg_feeder.md
# cipher_msg_feeder

Upstream feeder for `aes_enc_dec_module`, the byte-stream S-box cipher. It accepts a framed byte stream from the host over a valid/ready interface and buffers it in a small FIFO. For each message it issues a one-cycle `new_msg` pulse with a frozen per-message key, then one-cycle `in_valid` strobes. After each strobe it waits for the cipher's `out_flag`, or a timeout, before presenting the next byte.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `TIMEOUT`, 15: maximum WAIT cycles before a forced advance; range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: feeder can accept a byte.
- `s_data` in 8: host byte.
- `s_last` in 1: marks the final byte of a message.
- `key_load` in 1: capture `key_in` into the shadow register.
- `key_in` in 8: next-message key.
- `out_flag` in 1: cipher result-ready indication.
- `new_msg` out 1: start-of-message pulse to the cipher.
- `in_valid` out 1: byte strobe to the cipher.
- `in` out 8: byte to the cipher.
- `key` out 8: key to the cipher; stable for a whole message.
- `timeout_err` out 1: sticky flag, set when any WAIT times out.
- Reset behaviour: one clock; reset is asynchronous and active-low.

## Operation
- **FIFO entry.** Each entry is 9 bits: `{last, data}`.
- **Push.** A push occurs when `s_valid && s_ready`.
- **`s_ready`.** Equals `!full`. It is forced 0 while `rst_n` is low.
- **No bypass.** A byte pushed into an empty FIFO is visible to the FSM on the next cycle.
- **Shadow key.** `key_load` writes `key_in` into the shadow register.
- **Key freeze.** `key` is loaded from the shadow only on the IDLE->NEWMSG transition. A `key_load` mid-message affects the next message only.
- **FSM states.** The FSM is Moore and registered, with states IDLE, NEWMSG, READY, SEND, WAIT.
  - IDLE: if the FIFO is non-empty, go to NEWMSG and load `key`.
  - NEWMSG: `new_msg`=1 for exactly one cycle, then go to READY.
  - READY: if the FIFO is non-empty, pop the head into the `in` register and the `last_r` flag, then go to SEND. Otherwise stay; `new_msg` is not re-issued.
  - SEND: `in_valid`=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
  - WAIT: exit when `out_flag` is sampled high, or when the counter reaches TIMEOUT. A timeout sets `timeout_err`. On exit go to IDLE if `last_r`, else READY.
  - WAIT counter: increments once per WAIT cycle; 8 bits, no wrap.
- **Strobe spacing.** `in_valid` is never high on two consecutive cycles.
- **`out_flag` outside WAIT.** `out_flag` is ignored in every state except WAIT.
- **Output hold.** `in` holds the last byte sent until the next pop.
- **`timeout_err` clearing.** It clears only on reset.
- **Message boundaries.** Back-to-back messages in the FIFO each get their own NEWMSG, with one IDLE cycle in between.
- **Full FIFO.** When full, `s_ready` is 0 and the pop in READY frees an entry; `s_ready` rises the next cycle.
- **Reset mid-operation.** Reset flushes the FIFO and returns the FSM to IDLE. No `new_msg` or `in_valid` is emitted on reset release. `key`, the shadow key and `in` return to 0.

## Timing
- **Reset values.**
  - `new_msg`, `in_valid` and `timeout_err` reset to 0.
  - `in` and `key` reset to 8'h00.
  - `s_ready` is 0 during reset and 1 in the first cycle after release.
- **First-byte latency.** Accept the first byte on edge t0. Then:
  - `new_msg` is high during cycle t1..t2.
  - The FSM is in READY during t2..t3.
  - `in_valid` is high during t3..t4.
- **Minimum per-byte period.** 3 cycles: SEND, one WAIT cycle with `out_flag` present, READY.
- **Maximum per-byte period.** TIMEOUT+2 cycles when `out_flag` never arrives.

## Configuration
- **`FEEDER_STATS_EN` defined:** adds two output ports.
  - `msg_count[15:0]` increments on each NEWMSG.
  - `byte_count[15:0]` increments on each SEND.
  - Both wrap at 16'hFFFF->0 and reset to 0.
- **`FEEDER_STATS_EN` undefined:** the ports and counters are absent and all other behaviour is identical.

## Structure
- **Package `cipher_feeder_pkg`.** Holds:
  - the FSM state enum;
  - the packed struct `fifo_entry_t` `{last, data[7:0]}`;
  - the width constant for the WAIT counter.
- **Sub-module `sync_fifo`.** Parameterised on DEPTH and entry type. Provides:
  - a registered head;
  - `full` and `empty` flags;
  - a pointer with one extra wrap bit.

## Test plan
- **Single message.** Reset, `key_load` 8'hAA, push 5 bytes 8'h01..8'h05 with `s_last` on the fifth. `out_flag` returns 1 cycle after each `in_valid`. Required:
  - one `new_msg`, with `key`=8'hAA;
  - 5 `in_valid` pulses carrying 8'h01..8'h05 in order;
  - each pulse 3 cycles apart;
  - FSM back in IDLE.
- **Timeout.** Same message with `out_flag` tied 0 and TIMEOUT=15. Required: pulses 17 cycles apart and `timeout_err`=1.
- **Full FIFO.** Hold `out_flag` 0 and push 9 bytes into DEPTH=8. Required: `s_ready` drops after 8 accepted, and the ninth is accepted only after the first pop.
- **Key change mid-message.** Two back-to-back messages with `key_load` 8'h55 during the first. Required: first message `key`=8'hAA, second `key`=8'h55, separate `new_msg` pulses.
- **Reset mid-message.** Assert reset during WAIT of byte 3. Required:
  - all outputs return to reset values;
  - after release, with no new input, no `in_valid` occurs.
- **Stats.** With `FEEDER_STATS_EN`, after the first two scenarios: `msg_count`=2 and `byte_count`=10.
